// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants and types for the UART receive FIFO slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Default received-byte width
    localparam int C_DATA_W     = 8;

    // Default receive FIFO depth (entries, power of two)
    localparam int C_FIFO_DEPTH = 16;

    // One received byte
    typedef logic [C_DATA_W-1:0] uart_byte_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_mem
//  Description : DEPTH x DATA_W storage array with one synchronous write port
//                and one combinational (show-ahead) read port. Contents are
//                intentionally not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write the addressed entry on a push
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Head entry is visible without a clock so the reader sees it at once
    assign o_rdata = r_mem[i_raddr];

endmodule : fifo_mem
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Receive FIFO between a serial byte receiver and a CPU.
//                Show-ahead read data, registered occupancy/flags, sticky
//                overrun flag for bytes dropped while full.
//  Config      : define UART_RX_OVERRUN_EN to enable the overrun flag;
//                without it overrun is tied to 0 and clr_overrun is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = C_FIFO_DEPTH,
    parameter int DATA_W = C_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_valid,
    input  logic [DATA_W-1:0]      rx_data,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   data_ready,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overrun,
    input  logic                   clr_overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_ready;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_nxt;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept
    assign w_pop  = rd_en & r_ready;
    assign w_push = rx_valid & (~r_full | w_pop);

    // Next occupancy from the push/pop pair
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_ONE;
        end
    end

    // Pointers, count and flags all derive from the same next count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_FULL);
            r_ready <= (w_count_nxt != '0);
        end
    end

`ifdef UART_RX_OVERRUN_EN
    logic w_drop;
    logic r_overrun;

    assign w_drop = rx_valid & ~w_push;

    // Sticky drop flag; a drop in the clearing cycle keeps it set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    assign overrun = r_overrun;
`else
    logic w_unused_clr;

    assign w_unused_clr = clr_overrun;
    assign overrun      = 1'b0;
`endif

    fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (rx_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (rd_data)
    );

    assign count      = r_count;
    assign full       = r_full;
    assign data_ready = r_ready;

endmodule : uart_rx_fifo
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Self-checking bench for uart_rx_fifo. A queue-based model
//                tracks expected contents and the overrun flag; directed
//                scenarios are followed by randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                clk;
    logic                rst;
    logic                rx_valid;
    logic [C_DATA_W-1:0] rx_data;
    logic                rd_en;
    logic [C_DATA_W-1:0] rd_data;
    logic                data_ready;
    logic                full;
    logic [CW-1:0]       count;
    logic                overrun;
    logic                clr_overrun;

    int n_cmp;
    int n_err;

    // Reference model: queue of stored bytes, oldest first
    uart_byte_t m_q[$];
    logic       m_ovr;

    uart_rx_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (C_DATA_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .data_ready  (data_ready),
        .full        (full),
        .count       (count),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Compare every visible output against the model
    task automatic check_outputs();
        check_val("data_ready", {31'd0, data_ready}, {31'd0, (m_q.size() != 0)});
        check_val("count", {{(32-CW){1'b0}}, count}, m_q.size());
        check_val("full", {31'd0, full}, {31'd0, (m_q.size() == DEPTH)});
        check_val("overrun", {31'd0, overrun}, {31'd0, m_ovr});
        if (m_q.size() != 0) begin
            check_val("rd_data", {24'd0, rd_data}, {24'd0, m_q[0]});
        end
    endtask

    // One clock: check at negedge, drive, advance model at posedge
    task automatic step(input logic v, input logic [7:0] d, input logic r, input logic c);
        bit do_pop;
        bit do_push;
        check_outputs();
        rx_valid    = v;
        rx_data     = d;
        rd_en       = r;
        clr_overrun = c;
        @(posedge clk);
        do_pop  = r && (m_q.size() != 0);
        do_push = v && ((m_q.size() < DEPTH) || do_pop);
        if (do_pop)  void'(m_q.pop_front());
        if (do_push) m_q.push_back(d);
`ifdef UART_RX_OVERRUN_EN
        if (v && !do_push) m_ovr = 1'b1;
        else if (c)        m_ovr = 1'b0;
`endif
        @(negedge clk);
        rx_valid    = 1'b0;
        rd_en       = 1'b0;
        clr_overrun = 1'b0;
    endtask

    task automatic fill_seq();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    endtask

    task automatic drain();
        while (m_q.size() != 0) step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        m_ovr       = 1'b0;
        rst         = 1'b1;
        rx_valid    = 1'b0;
        rx_data     = '0;
        rd_en       = 1'b0;
        clr_overrun = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check_outputs();

        // Two bytes in, two out, in order
        step(1'b1, 8'h41, 1'b0, 1'b0);
        check_val("first_head", {24'd0, rd_data}, 32'h41);
        step(1'b1, 8'h42, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_val("second_head", {24'd0, rd_data}, 32'h42);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_val("empty_after_pops", {31'd0, data_ready}, 32'd0);

        // Fill to DEPTH, drop one extra byte, drain in order
        fill_seq();
        check_val("full_flag", {31'd0, full}, 32'd1);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
`ifdef UART_RX_OVERRUN_EN
        check_val("ovr_after_drop", {31'd0, overrun}, 32'd1);
`else
        check_val("ovr_after_drop", {31'd0, overrun}, 32'd0);
`endif
        for (int i = 0; i < DEPTH; i++) begin
            check_val("drain_order", {24'd0, rd_data}, i);
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check_val("ovr_cleared", {31'd0, overrun}, 32'd0);

        // Full with simultaneous push and pop
        fill_seq();
        check_val("head_before_swap", {24'd0, rd_data}, 32'h00);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        check_val("count_after_swap", {{(32-CW){1'b0}}, count}, DEPTH);
        check_val("ovr_after_swap", {31'd0, overrun}, 32'd0);
        for (int i = 1; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check_val("last_is_aa", {24'd0, rd_data}, 32'hAA);
        drain();

        // Empty with simultaneous push and pop
        step(1'b1, 8'h55, 1'b1, 1'b0);
        check_val("count_after_empty_swap", {{(32-CW){1'b0}}, count}, 32'd1);
        check_val("head_55", {24'd0, rd_data}, 32'h55);
        drain();

        // Drop and clear in the same cycle: set wins
        fill_seq();
        step(1'b1, 8'hFF, 1'b0, 1'b1);
`ifdef UART_RX_OVERRUN_EN
        check_val("ovr_set_wins", {31'd0, overrun}, 32'd1);
`else
        check_val("ovr_set_wins", {31'd0, overrun}, 32'd0);
`endif
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check_val("ovr_clr_alone", {31'd0, overrun}, 32'd0);
        step(1'b1, 8'hFE, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle with traffic in flight
        drain();
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0);
        step(1'b1, 8'h03, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_val("rst_ready", {31'd0, data_ready}, 32'd0);
        check_val("rst_count", {{(32-CW){1'b0}}, count}, 32'd0);
        check_val("rst_ovr", {31'd0, overrun}, 32'd0);
        m_q.delete();
        m_ovr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'h77, 1'b0, 1'b0);
        check_val("post_rst_head", {24'd0, rd_data}, 32'h77);
        drain();

        // Randomized traffic, phases biased toward filling and draining
        for (int ph = 0; ph < 8; ph++) begin
            int pv;
            int pr;
            pv = (ph % 2 == 0) ? 80 : 35;
            pr = (ph % 2 == 0) ? 30 : 75;
            for (int k = 0; k < 200; k++) begin
                step(($urandom_range(99) < pv) ? 1'b1 : 1'b0,
                     8'($urandom()),
                     ($urandom_range(99) < pr) ? 1'b1 : 1'b0,
                     ($urandom_range(99) < 8) ? 1'b1 : 1'b0);
            end
        end
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_uart_rx_fifo
`default_nettype wire

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
- REQ-001: Parameter DEPTH, default 16, meaning FIFO entries; it SHALL be a power of two, at least 2.
- REQ-002: Parameter DATA_W, default 8, meaning byte width.
- REQ-003: Port clk, input, 1 bit: single clock; all state SHALL be on its rising edge.
- REQ-004: Port rst, input, 1 bit: reset, asynchronous and active-high.
- REQ-005: Port rx_valid, input, 1 bit: one-cycle strobe from the serial receiver that a byte is complete.
- REQ-006: Port rx_data, input, DATA_W bits: received byte, valid when rx_valid=1.
- REQ-007: Port rd_en, input, 1 bit: CPU pop request.
- REQ-008: Port rd_data, output, DATA_W bits: head-of-FIFO byte (show-ahead).
- REQ-009: Port data_ready, output, 1 bit: FIFO not empty.
- REQ-010: Port full, output, 1 bit: FIFO holds DEPTH entries.
- REQ-011: Port count, output, $clog2(DEPTH)+1 bits: current occupancy.
- REQ-012: Port overrun, output, 1 bit: sticky dropped-byte flag.
- REQ-013: Port clr_overrun, input, 1 bit: clears overrun.

Function
- REQ-014: Push SHALL occur when rx_valid=1 and (full=0 or a pop occurs in the same cycle).
- REQ-015: Pop SHALL occur when rd_en=1 and data_ready=1; rd_en while empty SHALL be ignored with no state change.
- REQ-016: A byte pushed at edge N SHALL appear on rd_data with data_ready=1 after edge N, i.e. one cycle of latency; there SHALL be no same-cycle bypass from rx_data.
- REQ-017: rd_data SHALL equal the oldest stored byte whenever data_ready=1; it is don't-care while empty.
- REQ-018: Read and write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
- REQ-019: Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
- REQ-020: Full with rx_valid=1 and rd_en=1 SHALL pop and push, keep full=1, and not set overrun.
- REQ-021: Empty with rx_valid=1 and rd_en=1 SHALL push only; count becomes 1.
- REQ-022: Full with rx_valid=1 and no pop SHALL drop the byte, leaving contents and count unchanged.
- REQ-023: count, full and data_ready SHALL be registered and consistent with each other on every cycle.

Reset
- REQ-024: rst=1 SHALL asynchronously force pointers=0, count=0, data_ready=0, full=0, overrun=0; storage contents are not reset.
- REQ-025: rst asserted mid-traffic SHALL discard all stored bytes; the first push after deassertion SHALL be at index 0.

Configuration
- REQ-026: With UART_RX_OVERRUN_EN defined, the REQ-022 drop SHALL set overrun; overrun SHALL stay 1 until clr_overrun=1. On a cycle with both a drop and clr_overrun=1, overrun SHALL be 1 after the edge (set wins).
- REQ-027: Without UART_RX_OVERRUN_EN, overrun SHALL be constant 0, clr_overrun SHALL be ignored, and drops SHALL still occur silently.

Structure
- REQ-028: Package uart_pkg SHALL hold DATA_W default (8), the byte typedef and the default FIFO depth constant.
- REQ-029: Storage SHALL be the sub-module fifo_mem: DEPTH x DATA_W, one synchronous write port and one combinational read port. Pointer, count and flag logic stays in uart_rx_fifo.

Verification
- REQ-030: After reset, push 0x41 then 0x42 -> data_ready=1 one cycle after the first push; rd_data=0x41, pop, then rd_data=0x42; after the second pop count=0 and data_ready=0.
- REQ-031: Push 16 bytes 0x00..0x0F with DEPTH=16 -> full=1, count=16; a 17th push of 0xFF is dropped, overrun=1 (with macro), and the pops return 0x00..0x0F in order.
- REQ-032: Full, rx_valid with 0xAA and rd_en in the same cycle -> popped byte is 0x00, count stays 16, overrun stays 0, and 0xAA is read last.
- REQ-033: Empty, rx_valid with 0x55 and rd_en in the same cycle -> count=1, and rd_data=0x55 on the next cycle.
- REQ-034: Push 3 bytes, assert rst mid-cycle -> data_ready, count and overrun go to 0 immediately; the next push 0x77 is read back as 0x77.
- REQ-035: Overrun drop in the same cycle as clr_overrun=1 -> overrun=1; clr_overrun alone on a later cycle -> overrun=0. Built without the macro, overrun stays 0 throughout.
